mem_line_engine: RTL and testbench
==================================

# mem_line_engine

Cache-side initiator for the external memory request/data/response protocol. It converts one cache-line command (read refill or masked writeback) into a sequence of per-beat memory requests and, for reads, reassembles the tagged responses into a full line. It sits between a cache controller and the external memory port of the top level, in place of ad-hoc request logic inside each cache.

## Interface
Parameters:
- MEM_ADDR_BITS, 28, beat address width (byte address >> 4)
- MEM_DATA_BITS, 128, beat data width
- MEM_TAG_BITS, 5, request/response tag width
- BEATS, 4, beats per line (power of two; line = BEATS*MEM_DATA_BITS bits)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- cmd_valid  in  1  line command offered
- cmd_ready  out  1  engine idle, accepts command
- cmd_rw  in  1  0 = line read, 1 = line write
- cmd_line_addr  in  MEM_ADDR_BITS-log2(BEATS)  line address
- cmd_wdata  in  BEATS*MEM_DATA_BITS  write line, beat 0 in LSBs
- cmd_wmask  in  BEATS*MEM_DATA_BITS/8  byte enables for write line
- done_valid  out  1  one-cycle completion pulse
- done_rdata  out  BEATS*MEM_DATA_BITS  assembled read line (valid with done_valid after a read)
- mem_req_valid / mem_req_ready  out / in  1  request handshake
- mem_req_rw  out  1  request direction
- mem_req_addr  out  MEM_ADDR_BITS  {line_addr, beat}
- mem_req_tag  out  MEM_TAG_BITS  beat index, zero-extended
- mem_req_data_valid / mem_req_data_ready  out / in  1  write-data handshake
- mem_req_data_bits  out  MEM_DATA_BITS  write beat
- mem_req_data_mask  out  MEM_DATA_BITS/8  write beat byte enables
- mem_resp_valid  in  1  read response present
- mem_resp_tag  in  MEM_TAG_BITS  response tag
- mem_resp_data  in  MEM_DATA_BITS  response beat

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_DATA, DONE.
- IDLE: cmd_ready=1. A cmd_valid&&cmd_ready handshake latches addr, rw, wdata and wmask, clears the beat counter and the received bitmap, and goes to RD_REQ or WR_REQ.
- RD_REQ: mem_req_valid=1, rw=0, addr={line,issue_cnt}, tag=issue_cnt. Each req handshake increments issue_cnt. After beat BEATS-1 is accepted, go to RD_WAIT.
- Responses are accepted in RD_REQ and RD_WAIT, in any order. A response writes data into slot tag[log2(BEATS)-1:0] and sets that slot's bit in the received bitmap. When all bits are set, go to DONE. The response that completes the line and the final request may fall in the same cycle.
- WR_REQ: skip any beat whose mask slice is all-zero, with no bus activity for it. For a non-empty beat, assert req (rw=1, tag=beat). On handshake go to WR_DATA.
- WR_DATA: mem_req_data_valid=1 with the beat's data and mask. On handshake, go to WR_REQ for the next non-empty beat, or to DONE after the last one.
- A write with an all-zero cmd_wmask goes to DONE in the cycle after acceptance, with no requests issued.
- DONE: done_valid=1 for exactly one cycle, then IDLE. done_rdata holds its value until the next read completes.
- Responses outside RD_REQ/RD_WAIT are ignored. A response for a slot already received overwrites the data and leaves the bitmap unchanged.

## Timing
- Reset (reset==0 at posedge): state IDLE; cmd_ready=1; done_valid, mem_req_valid and mem_req_data_valid =0; addr, tag, data, mask and done_rdata =0. Reset mid-transfer abandons the transfer with no completion pulse.
- All outputs are registered or decoded from state only. There is no combinational path from the mem_*_ready inputs to the valid outputs.
- Once valid is asserted, it and its payload stay stable until ready. Requests are issued back-to-back, one per cycle while mem_req_ready=1.
- Minimum read latency: command at cycle 0, requests at cycles 1..BEATS, done_valid the cycle after the last response is captured.
- Minimum full write (BEATS=4): 8 handshake cycles plus DONE.

## Test plan
- Read, responses in order with latency 3: line 0x10 → requests to addr 0x40..0x43 with tags 0..3 → done_rdata = {r3,r2,r1,r0}, done_valid high for exactly 1 cycle.
- Read, responses in order 2,0,3,1 with mem_req_ready toggling 1/0 → requests stay stable while stalled; assembled line is correct.
- Write, full mask, data beats 0xA..D, line 0x7 → four req/data pairs to 0x1C..0x1F with rw=1; done follows the last data handshake; no responses expected.
- Write, mask only in beat 2 (0x00FF) → exactly one request, to addr {line,2}, with mask 0x00FF; all-zero mask → no bus activity and done_valid 2 cycles after the command.
- Stray mem_resp_valid while in IDLE or during a write → ignored; done_rdata unchanged.
- Reset asserted after two read requests → all outputs at their reset values next cycle; a fresh read then completes normally.

Source files
------------

// File: rtl/mem_line_engine.sv
// Cache-line initiator: splits one line read/write into per-beat memory requests
// and reassembles tagged read responses (any order) into a full line.
module mem_line_engine #(
    parameter int MEM_ADDR_BITS = 28,
    parameter int MEM_DATA_BITS = 128,
    parameter int MEM_TAG_BITS  = 5,
    parameter int BEATS         = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      cmd_valid,
    output logic                                      cmd_ready,
    input  logic                                      cmd_rw,
    input  logic [MEM_ADDR_BITS-$clog2(BEATS)-1:0]    cmd_line_addr,
    input  logic [BEATS*MEM_DATA_BITS-1:0]            cmd_wdata,
    input  logic [BEATS*MEM_DATA_BITS/8-1:0]          cmd_wmask,
    output logic                                      done_valid,
    output logic [BEATS*MEM_DATA_BITS-1:0]            done_rdata,
    output logic                                      mem_req_valid,
    input  logic                                      mem_req_ready,
    output logic                                      mem_req_rw,
    output logic [MEM_ADDR_BITS-1:0]                  mem_req_addr,
    output logic [MEM_TAG_BITS-1:0]                   mem_req_tag,
    output logic                                      mem_req_data_valid,
    input  logic                                      mem_req_data_ready,
    output logic [MEM_DATA_BITS-1:0]                  mem_req_data_bits,
    output logic [MEM_DATA_BITS/8-1:0]                mem_req_data_mask,
    input  logic                                      mem_resp_valid,
    input  logic [MEM_TAG_BITS-1:0]                   mem_resp_tag,
    input  logic [MEM_DATA_BITS-1:0]                  mem_resp_data
);
    localparam int BW = $clog2(BEATS);
    localparam int LW = MEM_ADDR_BITS - BW;
    localparam int MW = MEM_DATA_BITS / 8;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_DATA, DONE} state_t;
    state_t state;

    logic [LW-1:0]                       line_q;
    logic [BEATS-1:0][MEM_DATA_BITS-1:0] wdata_q, line_buf, line_next;
    logic [BEATS-1:0][MW-1:0]            wmask_q, srch_mask;
    logic [BW-1:0]                       issue_cnt, issue_nxt, wr_beat, srch_idx;
    logic [BW:0]                         srch_start;
    logic [BEATS-1:0]                    rcv, rcv_next;
    logic                                rsp_hit, req_fire, data_fire, last_issue, line_full;
    logic                                srch_found;
    logic                                unused_tag_hi;

    assign unused_tag_hi = ^mem_resp_tag[MEM_TAG_BITS-1:BW];

    assign rsp_hit    = mem_resp_valid && (state == RD_REQ || state == RD_WAIT);
    assign req_fire   = mem_req_valid && mem_req_ready;
    assign data_fire  = mem_req_data_valid && mem_req_data_ready;
    assign issue_nxt  = issue_cnt + 1'b1;
    assign last_issue = req_fire && (issue_cnt == BW'(BEATS-1));
    assign line_full  = &rcv_next;

    // Line image and bitmap including this cycle's response, so the final
    // response can complete the line on the same edge it is captured.
    always_comb begin
        line_next = line_buf;
        rcv_next  = rcv;
        if (rsp_hit) begin
            line_next[mem_resp_tag[BW-1:0]] = mem_resp_data;
            rcv_next[mem_resp_tag[BW-1:0]]  = 1'b1;
        end
    end

    // Lowest non-empty write beat at or after srch_start; in IDLE this looks
    // at the incoming mask so the first request is registered on acceptance.
    always_comb begin
        srch_mask  = (state == IDLE) ? cmd_wmask : wmask_q;
        srch_start = (state == IDLE) ? '0 : (BW+1)'(wr_beat) + (BW+1)'(1);
        srch_found = 1'b0;
        srch_idx   = '0;
        for (int b = BEATS-1; b >= 0; b--) begin
            if ((b >= int'(srch_start)) && (|srch_mask[b])) begin
                srch_found = 1'b1;
                srch_idx   = BW'(b);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state              <= IDLE;
            cmd_ready          <= 1'b1;
            done_valid         <= 1'b0;
            done_rdata         <= '0;
            mem_req_valid      <= 1'b0;
            mem_req_rw         <= 1'b0;
            mem_req_addr       <= '0;
            mem_req_tag        <= '0;
            mem_req_data_valid <= 1'b0;
            mem_req_data_bits  <= '0;
            mem_req_data_mask  <= '0;
            line_q             <= '0;
            wdata_q            <= '0;
            wmask_q            <= '0;
            line_buf           <= '0;
            rcv                <= '0;
            issue_cnt          <= '0;
            wr_beat            <= '0;
        end else begin
            done_valid <= 1'b0;
            if (rsp_hit) begin
                line_buf <= line_next;
                rcv      <= rcv_next;
            end
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready  <= 1'b0;
                        line_q     <= cmd_line_addr;
                        wdata_q    <= cmd_wdata;
                        wmask_q    <= cmd_wmask;
                        issue_cnt  <= '0;
                        rcv        <= '0;
                        mem_req_rw <= cmd_rw;
                        if (!cmd_rw) begin
                            state         <= RD_REQ;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= {cmd_line_addr, {BW{1'b0}}};
                            mem_req_tag   <= '0;
                        end else begin
                            // An all-empty mask leaves valid low; WR_REQ then finishes.
                            state         <= WR_REQ;
                            mem_req_valid <= srch_found;
                            wr_beat       <= srch_idx;
                            mem_req_addr  <= {cmd_line_addr, srch_idx};
                            mem_req_tag   <= MEM_TAG_BITS'(srch_idx);
                        end
                    end
                end
                RD_REQ: begin
                    if (req_fire) begin
                        if (last_issue) begin
                            mem_req_valid <= 1'b0;
                            if (line_full) begin
                                state      <= DONE;
                                done_valid <= 1'b1;
                                done_rdata <= line_next;
                            end else begin
                                state <= RD_WAIT;
                            end
                        end else begin
                            issue_cnt    <= issue_nxt;
                            mem_req_addr <= {line_q, issue_nxt};
                            mem_req_tag  <= MEM_TAG_BITS'(issue_nxt);
                        end
                    end
                end
                RD_WAIT: begin
                    if (line_full) begin
                        state      <= DONE;
                        done_valid <= 1'b1;
                        done_rdata <= line_next;
                    end
                end
                WR_REQ: begin
                    if (!mem_req_valid) begin
                        state      <= DONE;
                        done_valid <= 1'b1;
                    end else if (req_fire) begin
                        state              <= WR_DATA;
                        mem_req_valid      <= 1'b0;
                        mem_req_data_valid <= 1'b1;
                        mem_req_data_bits  <= wdata_q[wr_beat];
                        mem_req_data_mask  <= wmask_q[wr_beat];
                    end
                end
                WR_DATA: begin
                    if (data_fire) begin
                        mem_req_data_valid <= 1'b0;
                        if (srch_found) begin
                            state         <= WR_REQ;
                            wr_beat       <= srch_idx;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= {line_q, srch_idx};
                            mem_req_tag   <= MEM_TAG_BITS'(srch_idx);
                        end else begin
                            state      <= DONE;
                            done_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_line_engine.sv
// Bench for mem_line_engine: table vectors, randomized lines against a
// scoreboard memory model, plus stray-response and mid-transfer reset sequences.
module tb_mem_line_engine;
    localparam int AW = 28, DW = 128, TW = 5, NB = 4;
    localparam int LW = AW - 2, MW = DW / 8;

    logic clk = 1'b0;
    logic reset;
    logic cmd_valid, cmd_ready, cmd_rw;
    logic [LW-1:0] cmd_line_addr;
    logic [NB*DW-1:0] cmd_wdata, done_rdata;
    logic [NB*MW-1:0] cmd_wmask;
    logic done_valid;
    logic mem_req_valid, mem_req_ready, mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic [TW-1:0] mem_req_tag, mem_resp_tag;
    logic mem_req_data_valid, mem_req_data_ready;
    logic [DW-1:0] mem_req_data_bits, mem_resp_data;
    logic [MW-1:0] mem_req_data_mask;
    logic mem_resp_valid;

    always #5 clk = ~clk;

    mem_line_engine #(.MEM_ADDR_BITS(AW), .MEM_DATA_BITS(DW), .MEM_TAG_BITS(TW), .BEATS(NB)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_line_addr(cmd_line_addr), .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
        .done_valid(done_valid), .done_rdata(done_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data)
    );

    typedef struct {
        bit          rw;
        logic [25:0] line;
        logic [31:0] wbase;
        logic [3:0]  ben;
        logic [15:0] mval;
        int          rmode;   // 0 always ready, 1 toggling, 2 random
        logic [7:0]  ord;     // response k carries tag ord[2k+:2]
        int          lat;
        int          exp_nreq;
        logic [27:0] exp_addr0;
        int          exp_done;
    } vec_t;

    int tests = 0, fails = 0;
    logic [27:0]  ra_q[$];
    logic [4:0]   rt_q[$];
    logic         rw_q[$];
    logic [127:0] db_q[$];
    logic [15:0]  dm_q[$];
    int done_cnt, done_cycle, last_resp;
    bit stall_ok, stray_en, dup_en;
    logic [511:0] got_rdata, prev_rdata;
    logic [3:0][127:0] exp_line;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_done_valid"}, done_valid, 0);
        chk({tag, "_req_valid"}, mem_req_valid, 0);
        chk({tag, "_data_valid"}, mem_req_data_valid, 0);
        chk({tag, "_addr_tag"}, {mem_req_addr, mem_req_tag}, 0);
        chk({tag, "_data_mask"}, {mem_req_data_bits, mem_req_data_mask}, 0);
        chk({tag, "_done_rdata"}, done_rdata, 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // Drives one command and plays the memory side until completion.
    task automatic run_txn(input bit rw, input logic [25:0] line, input logic [511:0] wd,
                           input logic [63:0] wm, input int rmode, input logic [7:0] ord, input int lat);
        int cyc, k;
        int rq_cyc[4];
        bit rr, dr, pv_req_stall, pv_dat_stall;
        logic [27:0] pv_addr;
        logic [4:0] pv_tag;
        logic pv_rw;
        logic [127:0] pv_bits, d;
        logic [15:0] pv_mask;
        logic [1:0] t;
        ra_q.delete(); rt_q.delete(); rw_q.delete(); db_q.delete(); dm_q.delete();
        for (int i = 0; i < 4; i++) rq_cyc[i] = -1;
        k = 0; last_resp = -1; done_cnt = 0; done_cycle = -1; stall_ok = 1;
        pv_req_stall = 0; pv_dat_stall = 0; pv_addr = '0; pv_tag = '0; pv_rw = 0;
        pv_bits = '0; pv_mask = '0; exp_line = '0; got_rdata = '0;
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1; cmd_rw = rw; cmd_line_addr = line; cmd_wdata = wd; cmd_wmask = wm;
        @(posedge clk); #1;
        cmd_valid = 0;
        cyc = 1;
        while (cyc < 200 && !(done_cnt > 0 && cyc > done_cycle + 2)) begin
            if (pv_req_stall && !(mem_req_valid && mem_req_addr == pv_addr &&
                                  mem_req_tag == pv_tag && mem_req_rw == pv_rw)) stall_ok = 0;
            if (pv_dat_stall && !(mem_req_data_valid && mem_req_data_bits == pv_bits &&
                                  mem_req_data_mask == pv_mask)) stall_ok = 0;
            case (rmode)
                0: begin rr = 1; dr = 1; end
                1: begin rr = (cyc % 2) == 1; dr = (cyc % 2) == 0; end
                default: begin rr = $urandom_range(0, 3) != 0; dr = $urandom_range(0, 3) != 0; end
            endcase
            mem_req_ready = rr; mem_req_data_ready = dr;
            if (mem_req_valid && rr) begin
                ra_q.push_back(mem_req_addr); rt_q.push_back(mem_req_tag); rw_q.push_back(mem_req_rw);
                if (!mem_req_rw) rq_cyc[mem_req_tag[1:0]] = cyc;
            end
            if (mem_req_data_valid && dr) begin
                db_q.push_back(mem_req_data_bits); dm_q.push_back(mem_req_data_mask);
            end
            pv_req_stall = mem_req_valid && !rr;
            pv_addr = mem_req_addr; pv_tag = mem_req_tag; pv_rw = mem_req_rw;
            pv_dat_stall = mem_req_data_valid && !dr;
            pv_bits = mem_req_data_bits; pv_mask = mem_req_data_mask;
            mem_resp_valid = 0;
            if (!rw && k < 4) begin
                t = ord[2*k +: 2];
                if (rq_cyc[t] >= 0 && cyc >= rq_cyc[t] + lat) begin
                    d = rnd128();
                    mem_resp_valid = 1; mem_resp_tag = {3'($urandom_range(0, 7)), t}; mem_resp_data = d;
                    exp_line[t] = d; k++; last_resp = cyc;
                end else if (dup_en && k > 0 && $urandom_range(0, 3) == 0) begin
                    t = ord[2*$urandom_range(0, k-1) +: 2];
                    d = rnd128();
                    mem_resp_valid = 1; mem_resp_tag = {3'b000, t}; mem_resp_data = d;
                    exp_line[t] = d;
                end
            end else if (rw && stray_en && $urandom_range(0, 1) == 1) begin
                mem_resp_valid = 1; mem_resp_tag = 5'($urandom()); mem_resp_data = rnd128();
            end
            if (done_valid) begin
                done_cnt++;
                if (done_cycle < 0) begin done_cycle = cyc; got_rdata = done_rdata; end
            end
            @(posedge clk); #1;
            cyc++;
        end
        mem_resp_valid = 0; mem_req_ready = 0; mem_req_data_ready = 0;
    endtask

    // Expected bus traffic derived from the line command alone.
    task automatic check_txn(input bit rw, input logic [25:0] line, input logic [511:0] wd,
                             input logic [63:0] wm, input int exp_done, input int exp_nreq,
                             input logic [27:0] exp_a0);
        int n;
        if (done_cnt == 0) begin
            tests++; fails++;
            $display("FAIL timeout: got no done_valid within 200 cycles, expected one pulse");
            pulse_reset();
            prev_rdata = '0;
            return;
        end
        chk("done_pulses", done_cnt, 1);
        n = 0;
        for (int b = 0; b < 4; b++) begin
            if (!rw || wm[b*16 +: 16] != 16'h0) begin
                if (n < ra_q.size()) begin
                    chk("req_addr", ra_q[n], {line, 2'(b)});
                    chk("req_tag", rt_q[n], b);
                    chk("req_rw", rw_q[n], rw);
                end
                if (rw && n < db_q.size()) begin
                    chk("wr_data", db_q[n], wd[b*128 +: 128]);
                    chk("wr_mask", dm_q[n], wm[b*16 +: 16]);
                end
                n++;
            end
        end
        chk("req_count", ra_q.size(), n);
        chk("data_count", db_q.size(), rw ? n : 0);
        if (exp_nreq >= 0) chk("tbl_nreq", ra_q.size(), exp_nreq);
        if (exp_nreq > 0 && ra_q.size() > 0) chk("tbl_addr0", ra_q[0], exp_a0);
        if (exp_done >= 0) chk("done_cycle", done_cycle, exp_done);
        if (!rw) chk("rd_done_lat", done_cycle, last_resp + 1);
        chk("stall_stable", stall_ok, 1);
        if (rw) chk("done_rdata_hold", got_rdata, prev_rdata);
        else begin
            chk("done_rdata", got_rdata, exp_line);
            prev_rdata = exp_line;
        end
    endtask

    initial begin
        vec_t vecs[6];
        logic [511:0] wd;
        logic [63:0] wm;
        logic [1:0] p[4];
        logic [1:0] tmp;
        logic [7:0] ord;
        bit rw, seen;
        int j;

        vecs[0] = '{0, 26'h10, 32'h0, 4'h0, 16'h0,    0, 8'hE4, 3, 4, 28'h40,  8};
        vecs[1] = '{0, 26'h55, 32'h0, 4'h0, 16'h0,    1, 8'h72, 1, 4, 28'h154, -1};
        vecs[2] = '{1, 26'h07, 32'hA, 4'hF, 16'hFFFF, 0, 8'h0,  0, 4, 28'h1C,  9};
        vecs[3] = '{1, 26'h09, 32'h5, 4'h4, 16'h00FF, 0, 8'h0,  0, 1, 28'h26,  3};
        vecs[4] = '{1, 26'h03, 32'h1, 4'h0, 16'h0,    0, 8'h0,  0, 0, 28'h0,   2};
        vecs[5] = '{1, 26'h2A, 32'h9, 4'hA, 16'hFFFF, 1, 8'h0,  0, 2, 28'hA9,  -1};

        reset = 0; cmd_valid = 0; cmd_rw = 0; cmd_line_addr = '0; cmd_wdata = '0; cmd_wmask = '0;
        mem_req_ready = 0; mem_req_data_ready = 0; mem_resp_valid = 0; mem_resp_tag = '0; mem_resp_data = '0;
        prev_rdata = '0; stray_en = 1; dup_en = 0;
        @(posedge clk); @(posedge clk); #1;
        check_reset_vals("rst");
        reset = 1;
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++) begin
            for (int b = 0; b < 4; b++) begin
                wd[b*128 +: 128] = 128'(vecs[v].wbase + 32'(b));
                wm[b*16 +: 16]   = vecs[v].ben[b] ? vecs[v].mval : 16'h0;
            end
            run_txn(vecs[v].rw, vecs[v].line, wd, wm, vecs[v].rmode, vecs[v].ord, vecs[v].lat);
            check_txn(vecs[v].rw, vecs[v].line, wd, wm, vecs[v].exp_done, vecs[v].exp_nreq, vecs[v].exp_addr0);
        end

        // Stray responses while idle must be dropped.
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            mem_resp_valid = 1; mem_resp_tag = 5'($urandom()); mem_resp_data = rnd128();
            @(posedge clk); #1;
            if (done_valid) seen = 1;
        end
        mem_resp_valid = 0;
        chk("idle_stray_no_done", seen, 0);
        chk("idle_stray_rdata", done_rdata, prev_rdata);

        dup_en = 1;
        for (int r = 0; r < 40; r++) begin
            rw = $urandom_range(0, 1) == 1;
            for (int b = 0; b < 4; b++) begin
                wd[b*128 +: 128] = rnd128();
                case ($urandom_range(0, 3))
                    0: wm[b*16 +: 16] = 16'h0;
                    1: wm[b*16 +: 16] = 16'hFFFF;
                    default: wm[b*16 +: 16] = 16'($urandom());
                endcase
            end
            for (int i = 0; i < 4; i++) p[i] = 2'(i);
            for (int i = 3; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = p[i]; p[i] = p[j]; p[j] = tmp;
            end
            ord = {p[3], p[2], p[1], p[0]};
            run_txn(rw, 26'($urandom()), wd, wm, 2, ord, $urandom_range(0, 4));
            check_txn(rw, cmd_line_addr, wd, wm, -1, -1, '0);
        end
        dup_en = 0;

        // Reset after two read requests were accepted abandons the read.
        cmd_valid = 1; cmd_rw = 0; cmd_line_addr = 26'h33; mem_req_ready = 1;
        @(posedge clk); #1;
        cmd_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("busy_cmd_ready", cmd_ready, 0);
        reset = 0;
        @(posedge clk); #1;
        reset = 1; mem_req_ready = 0;
        check_reset_vals("midrst");
        prev_rdata = '0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done_valid) seen = 1;
        end
        chk("midrst_no_done", seen, 0);
        wd = '0; wm = '0;
        run_txn(0, 26'h34, wd, wm, 0, 8'hE4, 2);
        check_txn(0, 26'h34, wd, wm, 7, 4, 28'hD0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
